// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, registered delivery, PC redirect.
// Optional build macro FETCH_ALIGN_CHECK_EN halts on a misaligned redirect target and raises o_fault.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        i_clock,
    input  logic        i_resetn,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemGnt,
    input  logic        i_imemValid,
    input  logic [31:0] i_imemData,
    output logic        o_instrValid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instrPC,
    input  logic        i_instrReady,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectPC,
    output logic        o_fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        HOLD,
        DROP,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        redirect_bad;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    assign redirect_bad = i_redirect && (i_redirectPC[1:0] != 2'b00);
    assign o_fault      = fault_q;
`else
    assign redirect_bad = 1'b0;
    assign o_fault      = 1'b0;
`endif

    assign o_imemAddr = pc;

    // A granted request always has a response on its way, so any redirect that
    // cuts it off routes through DROP (or straight to REQ if the response is here now).
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            o_imemReq    <= 1'b0;
            o_instrValid <= 1'b0;
            o_instr      <= 32'h0000_0000;
            o_instrPC    <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q      <= 1'b0;
`endif
        end else if (redirect_bad && (state != IDLE) && (state != HALT)) begin
            state        <= HALT;
            o_imemReq    <= 1'b0;
            o_instrValid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q      <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    o_imemReq <= 1'b1;
                end
                REQ: begin
                    if (i_redirect) begin
                        pc <= i_redirectPC;
                        if (i_imemGnt) begin
                            state     <= DROP;
                            o_imemReq <= 1'b0;
                        end
                    end else if (i_imemGnt) begin
                        state     <= RESP;
                        o_imemReq <= 1'b0;
                    end
                end
                RESP: begin
                    if (i_redirect) begin
                        pc <= i_redirectPC;
                        if (i_imemValid) begin
                            state     <= REQ;
                            o_imemReq <= 1'b1;
                        end else begin
                            state <= DROP;
                        end
                    end else if (i_imemValid) begin
                        state        <= HOLD;
                        o_instr      <= i_imemData;
                        o_instrPC    <= pc;
                        o_instrValid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (i_redirect) begin
                        pc           <= i_redirectPC;
                        state        <= REQ;
                        o_imemReq    <= 1'b1;
                        o_instrValid <= 1'b0;
                    end else if (i_instrReady) begin
                        pc           <= pc + 32'(PC_STEP);
                        state        <= REQ;
                        o_imemReq    <= 1'b1;
                        o_instrValid <= 1'b0;
                    end
                end
                DROP: begin
                    // Leaving on the discarded response even if a redirect arrives with it avoids waiting forever.
                    if (i_redirect) begin
                        pc <= i_redirectPC;
                    end
                    if (i_imemValid) begin
                        state     <= REQ;
                        o_imemReq <= 1'b1;
                    end
                end
                HALT: begin
                    state        <= HALT;
                    o_imemReq    <= 1'b0;
                    o_instrValid <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    o_imemReq    <= 1'b0;
                    o_instrValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; a second instance with RESET_PC=0xFFFF_FFFC covers PC wrap.
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        resetn;
    logic        imem_gnt, imem_valid, instr_ready, redirect;
    logic [31:0] imem_data, redirect_pc;
    logic        imem_req, instr_valid, fault;
    logic [31:0] imem_addr, instr, instr_pc;

    logic        w_resetn;
    logic        w_req, w_valid, w_fault;
    logic [31:0] w_addr, w_instr, w_pc;

    int tests_run = 0;
    int failures  = 0;

    always #5 clock = ~clock;

    fetch_ctrl u_dut (
        .i_clock(clock), .i_resetn(resetn),
        .o_imemReq(imem_req), .o_imemAddr(imem_addr),
        .i_imemGnt(imem_gnt), .i_imemValid(imem_valid), .i_imemData(imem_data),
        .o_instrValid(instr_valid), .o_instr(instr), .o_instrPC(instr_pc),
        .i_instrReady(instr_ready), .i_redirect(redirect), .i_redirectPC(redirect_pc),
        .o_fault(fault)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_wrap (
        .i_clock(clock), .i_resetn(w_resetn),
        .o_imemReq(w_req), .o_imemAddr(w_addr),
        .i_imemGnt(1'b1), .i_imemValid(1'b1), .i_imemData(32'h0000_0013),
        .o_instrValid(w_valid), .o_instr(w_instr), .o_instrPC(w_pc),
        .i_instrReady(1'b1), .i_redirect(1'b0), .i_redirectPC(32'h0000_0000),
        .o_fault(w_fault)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; w_resetn = 1'b0;
        imem_gnt = 1'b0; imem_valid = 1'b0; imem_data = 32'h0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step(); step();
        tests_run++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%0h exp=0", imem_req); end
        tests_run++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=00000000", imem_addr); end
        tests_run++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0h exp=0", instr_valid); end
        tests_run++; if (instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=00000000", instr); end
        tests_run++; if (instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=00000000", instr_pc); end
        tests_run++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault got=%0h exp=0", fault); end
        resetn = 1'b1;
        step();
        tests_run++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL idle_to_req got=%0h exp=1", imem_req); end
        tests_run++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL first_addr got=%h exp=00000000", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3] = '{32'h0000_0013, 32'h0040_0093, 32'h0080_0113};
        logic [31:0] exp_pc;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'(k * 4);
            tests_run++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL seq_req[%0d] got=%0h exp=1", k, imem_req); end
            tests_run++; if (imem_addr !== exp_pc) begin failures++; $display("[TB] FAIL seq_addr[%0d] got=%h exp=%h", k, imem_addr, exp_pc); end
            imem_gnt = 1'b1;
            step();
            tests_run++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL seq_resp_req[%0d] got=%0h exp=0", k, imem_req); end
            imem_gnt = 1'b0; imem_valid = 1'b1; imem_data = words[k];
            step();
            imem_valid = 1'b0;
            tests_run++; if (instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL seq_valid[%0d] got=%0h exp=1", k, instr_valid); end
            tests_run++; if (instr !== words[k]) begin failures++; $display("[TB] FAIL seq_instr[%0d] got=%h exp=%h", k, instr, words[k]); end
            tests_run++; if (instr_pc !== exp_pc) begin failures++; $display("[TB] FAIL seq_pc[%0d] got=%h exp=%h", k, instr_pc, exp_pc); end
            step();
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_valid = 1'b1; imem_data = 32'hCAFE_F00D;
        step();
        imem_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid[%0d] got=%0h exp=1", i, instr_valid); end
            tests_run++; if (instr !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL stall_instr[%0d] got=%h exp=cafef00d", i, instr); end
            tests_run++; if (instr_pc !== 32'h0000_000C) begin failures++; $display("[TB] FAIL stall_pc[%0d] got=%h exp=0000000c", i, instr_pc); end
            tests_run++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_req[%0d] got=%0h exp=0", i, imem_req); end
            tests_run++; if (imem_addr !== 32'h0000_000C) begin failures++; $display("[TB] FAIL stall_addr[%0d] got=%h exp=0000000c", i, imem_addr); end
            step();
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        tests_run++; if (imem_addr !== 32'h0000_0010) begin failures++; $display("[TB] FAIL stall_next_addr got=%h exp=00000010", imem_addr); end
        tests_run++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_release_valid got=%0h exp=0", instr_valid); end
    endtask

    task automatic test_redirect_resp();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        tests_run++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL drop_req got=%0h exp=0", imem_req); end
        imem_valid = 1'b1; imem_data = 32'hDEAD_BEEF;
        step();
        imem_valid = 1'b0;
        tests_run++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL drop_valid got=%0h exp=0", instr_valid); end
        tests_run++; if (instr !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL drop_instr got=%h exp=cafef00d", instr); end
        tests_run++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL drop_next_req got=%0h exp=1", imem_req); end
        tests_run++; if (imem_addr !== 32'h0000_0100) begin failures++; $display("[TB] FAIL drop_next_addr got=%h exp=00000100", imem_addr); end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_valid = 1'b1; imem_data = 32'h1234_5678;
        step();
        imem_valid = 1'b0;
        tests_run++; if (instr !== 32'h1234_5678) begin failures++; $display("[TB] FAIL target_instr got=%h exp=12345678", instr); end
        tests_run++; if (instr_pc !== 32'h0000_0100) begin failures++; $display("[TB] FAIL target_pc got=%h exp=00000100", instr_pc); end
    endtask

    task automatic test_redirect_hold();
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        instr_ready = 1'b0; redirect = 1'b0;
        tests_run++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_redir_valid got=%0h exp=0", instr_valid); end
        tests_run++; if (imem_addr !== 32'h0000_0200) begin failures++; $display("[TB] FAIL hold_redir_addr got=%h exp=00000200", imem_addr); end
        tests_run++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL hold_redir_req got=%0h exp=1", imem_req); end
    endtask

    task automatic test_redirect_with_valid();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_valid = 1'b1; imem_data = 32'hBADB_AD00;
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        step();
        imem_valid = 1'b0; redirect = 1'b0;
        tests_run++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL coinc_req got=%0h exp=1", imem_req); end
        tests_run++; if (imem_addr !== 32'h0000_0300) begin failures++; $display("[TB] FAIL coinc_addr got=%h exp=00000300", imem_addr); end
        tests_run++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL coinc_valid got=%0h exp=0", instr_valid); end
        tests_run++; if (instr !== 32'h1234_5678) begin failures++; $display("[TB] FAIL coinc_instr got=%h exp=12345678", instr); end
    endtask

    task automatic test_reset_midtxn();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        resetn = 1'b0;
        #1;
        tests_run++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_req got=%0h exp=0", imem_req); end
        tests_run++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL mid_reset_addr got=%h exp=00000000", imem_addr); end
        tests_run++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid got=%0h exp=0", instr_valid); end
        tests_run++; if (instr !== 32'h0) begin failures++; $display("[TB] FAIL mid_reset_instr got=%h exp=00000000", instr); end
        tests_run++; if (instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL mid_reset_pc got=%h exp=00000000", instr_pc); end
        imem_valid = 1'b1; imem_data = 32'hFFFF_0000;
        step(); step();
        tests_run++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL in_reset_valid got=%0h exp=0", instr_valid); end
        resetn = 1'b1;
        step();
        tests_run++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_req got=%0h exp=1", imem_req); end
        tests_run++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL post_reset_addr got=%h exp=00000000", imem_addr); end
        tests_run++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_resp_ignored got=%0h exp=0", instr_valid); end
        imem_valid = 1'b0;
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        tests_run++; if (fault !== 1'b1) begin failures++; $display("[TB] FAIL align_fault got=%0h exp=1", fault); end
        imem_gnt = 1'b1; imem_valid = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL halt_req[%0d] got=%0h exp=0", i, imem_req); end
            tests_run++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL halt_valid[%0d] got=%0h exp=0", i, instr_valid); end
            step();
        end
        imem_gnt = 1'b0; imem_valid = 1'b0; instr_ready = 1'b0;
        resetn = 1'b0;
        #1;
        tests_run++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL halt_reset_fault got=%0h exp=0", fault); end
        resetn = 1'b1;
`else
        tests_run++; if (imem_addr !== 32'h0000_0102) begin failures++; $display("[TB] FAIL unaligned_addr got=%h exp=00000102", imem_addr); end
        tests_run++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL unaligned_req got=%0h exp=1", imem_req); end
        tests_run++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL unaligned_fault got=%0h exp=0", fault); end
`endif
    endtask

    task automatic test_pc_wrap();
        logic [31:0] seen [2];
        int          n = 0;
        w_resetn = 1'b1;
        for (int i = 0; i < 20 && n < 2; i++) begin
            step();
            if (w_valid === 1'b1) begin
                seen[n] = w_pc;
                n++;
            end
        end
        tests_run++;
        if (n < 2) begin
            failures++; $display("[TB] FAIL wrap_timeout got=%0d transfers exp=2", n);
        end else begin
            if (seen[0] !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_first_pc got=%h exp=fffffffc", seen[0]); end
            tests_run++;
            if (seen[1] !== 32'h0000_0000) begin failures++; $display("[TB] FAIL wrap_second_pc got=%h exp=00000000", seen[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_resp();
        test_redirect_hold();
        test_redirect_with_valid();
        test_reset_midtxn();
        test_misaligned();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the address of the first fetch after reset.
REQ-002 Parameter PC_STEP, default 4, is the PC increment per sequential fetch.
REQ-003 i_clock  in  1  is the single clock; all state updates on its rising edge.
REQ-004 i_resetn  in  1  is the asynchronous, active-low reset.
REQ-005 o_imemReq  out  1  is the instruction memory request strobe.
REQ-006 o_imemAddr  out  32  is the fetch address, valid while o_imemReq=1.
REQ-007 i_imemGnt  in  1  is the memory accept; the request is taken when o_imemReq & i_imemGnt.
REQ-008 i_imemValid  in  1  is the response strobe, one or more cycles after grant.
REQ-009 i_imemData  in  32  is the response data, sampled when i_imemValid=1.
REQ-010 o_instrValid  out  1  is the downstream instruction-available flag.
REQ-011 o_instr  out  32  is the delivered instruction word.
REQ-012 o_instrPC  out  32  is the address of o_instr.
REQ-013 i_instrReady  in  1  is the downstream accept; transfer occurs on o_instrValid & i_instrReady.
REQ-014 i_redirect  in  1  is the single-cycle PC redirect strobe (branch/jump).
REQ-015 i_redirectPC  in  32  is the redirect target, sampled when i_redirect=1.
REQ-016 o_fault  out  1  is the sticky misaligned-target flag (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, REQ, RESP, HOLD, DROP, HALT.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-019 REQ SHALL drive o_imemReq=1, o_imemAddr=PC; on i_imemGnt go to RESP, else stay.
REQ-020 o_imemAddr SHALL remain stable while in REQ until grant, except on redirect.
REQ-021 RESP SHALL wait for i_imemValid, then capture i_imemData/PC into output registers and go to HOLD.
REQ-022 At most one request SHALL be outstanding; o_imemReq=0 in RESP, HOLD, DROP, HALT.
REQ-023 HOLD SHALL drive o_instrValid=1 with stable o_instr/o_instrPC until i_instrReady.
REQ-024 On transfer in HOLD, PC SHALL advance by PC_STEP (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000) and FSM go to REQ next cycle.
REQ-025 Redirect in REQ or HOLD SHALL load PC=i_redirectPC, drop o_instrValid, and go to REQ next cycle.
REQ-026 Redirect in RESP SHALL load PC and go to DROP; DROP discards the pending response, then goes to REQ.
REQ-027 Redirect coincident with i_imemValid in RESP SHALL discard that response and go directly to REQ.
REQ-028 Redirect coincident with a HOLD transfer SHALL take priority for PC; the transfer itself still completes.
REQ-029 Redirect in DROP SHALL update PC and remain in DROP.
REQ-030 Fetch-to-deliver latency SHALL be 1 cycle after i_imemValid (registered outputs).

Reset
REQ-031 Reset assertion SHALL immediately force IDLE, PC=RESET_PC, o_imemReq=0, o_imemAddr=RESET_PC, o_instrValid=0, o_instr=0, o_instrPC=0, o_fault=0.
REQ-032 Reset mid-transaction SHALL abandon any outstanding request; responses arriving during reset or IDLE SHALL be ignored.

Configuration
REQ-033 With FETCH_ALIGN_CHECK_EN defined, a redirect target with bits[1:0]!=0 SHALL set o_fault, enter HALT (no requests, o_instrValid=0) until reset.
REQ-034 Without FETCH_ALIGN_CHECK_EN, o_fault SHALL be tied 0 and targets used as given.

Verification
REQ-035 Reset release, i_imemGnt=1, 1-cycle response, i_instrReady=1 -> o_instrPC sequence 0x0, 0x4, 0x8, one instruction per 3 cycles.
REQ-036 i_instrReady=0 for 5 cycles in HOLD -> o_instr/o_instrPC held, o_imemReq=0 throughout, PC unchanged.
REQ-037 Redirect to 0x100 during RESP -> pending data 0xDEADBEEF never appears on o_instr; next o_imemAddr=0x100.
REQ-038 RESET_PC=0xFFFF_FFFC, two transfers -> second o_instrPC=0x0000_0000.
REQ-039 i_resetn low while in RESP, i_imemValid pulses during reset -> all outputs at reset values, first post-reset o_imemAddr=RESET_PC.
REQ-040 FETCH_ALIGN_CHECK_EN defined, redirect to 0x102 -> o_fault=1 next cycle, o_imemReq stays 0 until reset; undefined -> o_imemAddr=0x102.
